// File: rtl/thmn_bank.sv
// thmn_bank: bank of NCH weighted THmn NCL threshold gates with hysteresis,
// registered completion detection (all DATA / all NULL) and a DATA-wavefront counter.
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset (loads RST_VAL, clears counter)
//   en_i         evaluate enable; 0 freezes all state
//   x_i          gate inputs, channel c uses x_i[c*N +: N]
//   y_o          registered gate outputs
//   hold_o       combinational, channel neither sets nor clears this cycle
//   all_data_o   registered &y
//   all_null_o   registered ~|y
//   wave_cnt_o   wrapping count of all_data rising edges
module thmn_bank #(
    parameter int               N       = 4,
    parameter int               M       = 3,
    parameter int               NCH     = 1,
    parameter logic [23:0]      WT      = {8{3'd1}},
    parameter logic [NCH-1:0]   RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [NCH*N-1:0]     x_i,
    output logic [NCH-1:0]       y_o,
    output logic [NCH-1:0]       hold_o,
    output logic                 all_data_o,
    output logic                 all_null_o,
    output logic [CNT_W-1:0]     wave_cnt_o
);
    localparam int SW = $clog2(7 * N + 1);

    function automatic int wsum();
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(WT[3*i +: 3]);
        return s;
    endfunction

    function automatic bit wzero();
        bit z = 1'b0;
        for (int i = 0; i < N; i++) z |= (WT[3*i +: 3] == 3'd0);
        return z;
    endfunction

    if (M < 1 || M > wsum() || wzero()) begin : g_chk
        $fatal(1, "thmn_bank: M out of range or zero weight");
    end

    localparam logic [SW-1:0] MT = SW'(M);

    logic [NCH-1:0]   y_q, y_d;
    logic             ad_q, an_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    s;
    logic             st, cl;

    always_comb begin
        y_d    = y_q;
        hold_o = '0;
        s      = '0;
        st     = 1'b0;
        cl     = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            s = '0;
            for (int i = 0; i < N; i++) s = s + (x_i[c*N+i] ? SW'(WT[3*i +: 3]) : '0);
            st        = s >= MT;
            cl        = x_i[c*N +: N] == '0;
            hold_o[c] = !st && !cl;
            y_d[c]    = st ? 1'b1 : cl ? 1'b0 : y_q[c];
        end
        // ad_q doubles as the previous-cycle all_data used for edge detection
        cnt_d = (&y_d && !ad_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_q   <= RST_VAL;
            ad_q  <= &RST_VAL;
            an_q  <= ~|RST_VAL;
            cnt_q <= '0;
        end else if (en_i) begin
            y_q   <= y_d;
            ad_q  <= &y_d;
            an_q  <= ~|y_d;
            cnt_q <= cnt_d;
        end
    end

    assign y_o        = y_q;
    assign all_data_o = ad_q;
    assign all_null_o = an_q;
    assign wave_cnt_o = cnt_q;
endmodule

// File: tb/tb_thmn_bank.sv
// tb_thmn_bank: self-checking bench for thmn_bank across several parameter sets
module tb_thmn_bank;
    localparam int          NN  [5] = '{4, 4, 4, 4, 1};
    localparam int          MM  [5] = '{3, 2, 3, 3, 1};
    localparam int          NC  [5] = '{1, 1, 4, 4, 1};
    localparam int          CW  [5] = '{8, 8, 2, 8, 8};
    localparam logic [23:0] WTS [5] = '{{8{3'd1}}, {12'd0, 3'd1, 3'd1, 3'd1, 3'd2}, {8{3'd1}}, {8{3'd1}}, {8{3'd1}}};
    localparam logic [3:0]  RVS [5] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, en = 1'b1;
    logic [15:0] xin [5];
    logic [3:0]  dy [5], dh [5];
    logic        dad [5], dan [5];
    logic [7:0]  dc [5];

    logic       y0, h0, y1, h1, y4, h4;
    logic [3:0] y2, h2, y3, h3;
    logic [7:0] c0, c1, c3, c4;
    logic [1:0] c2;
    logic       ad0, an0, ad1, an1, ad2, an2, ad3, an3, ad4, an4;

    thmn_bank u0 (.clk_i(clk), .rst_i(rst), .en_i(en), .x_i(xin[0][3:0]), .y_o(y0), .hold_o(h0),
                  .all_data_o(ad0), .all_null_o(an0), .wave_cnt_o(c0));
    thmn_bank #(.M(2), .WT({12'd0, 3'd1, 3'd1, 3'd1, 3'd2})) u1 (.clk_i(clk), .rst_i(rst), .en_i(en),
                  .x_i(xin[1][3:0]), .y_o(y1), .hold_o(h1), .all_data_o(ad1), .all_null_o(an1), .wave_cnt_o(c1));
    thmn_bank #(.NCH(4), .CNT_W(2)) u2 (.clk_i(clk), .rst_i(rst), .en_i(en), .x_i(xin[2]), .y_o(y2),
                  .hold_o(h2), .all_data_o(ad2), .all_null_o(an2), .wave_cnt_o(c2));
    thmn_bank #(.NCH(4), .RST_VAL(4'hF)) u3 (.clk_i(clk), .rst_i(rst), .en_i(en), .x_i(xin[3]), .y_o(y3),
                  .hold_o(h3), .all_data_o(ad3), .all_null_o(an3), .wave_cnt_o(c3));
    thmn_bank #(.N(1), .M(1)) u4 (.clk_i(clk), .rst_i(rst), .en_i(en), .x_i(xin[4][0:0]), .y_o(y4),
                  .hold_o(h4), .all_data_o(ad4), .all_null_o(an4), .wave_cnt_o(c4));

    always_comb begin
        dy[0] = {3'b0, y0}; dh[0] = {3'b0, h0}; dad[0] = ad0; dan[0] = an0; dc[0] = c0;
        dy[1] = {3'b0, y1}; dh[1] = {3'b0, h1}; dad[1] = ad1; dan[1] = an1; dc[1] = c1;
        dy[2] = y2;         dh[2] = h2;         dad[2] = ad2; dan[2] = an2; dc[2] = {6'b0, c2};
        dy[3] = y3;         dh[3] = h3;         dad[3] = ad3; dan[3] = an3; dc[3] = c3;
        dy[4] = {3'b0, y4}; dh[4] = {3'b0, h4}; dad[4] = ad4; dan[4] = an4; dc[4] = c4;
    end

    int ncmp = 0, nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // threshold rule: {set, clear} for channel c of instance k
    function automatic logic [1:0] ev(input int k, input int c);
        int   s = 0;
        logic z = 1'b1;
        for (int i = 0; i < NN[k]; i++)
            if (xin[k][c*NN[k]+i]) begin
                s += int'(WTS[k][3*i +: 3]);
                z = 1'b0;
            end
        return {s >= MM[k], z};
    endfunction

    logic [3:0] my [5];
    logic       mad [5], man [5];
    int         mc [5];
    bit         live = 1'b0;

    always begin : model_and_compare
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] msk, ny;
            logic [1:0] e;
            msk = 4'((1 << NC[k]) - 1);
            if (rst) begin
                my[k]  = RVS[k] & msk;
                mad[k] = my[k] == msk;
                man[k] = my[k] == 4'h0;
                mc[k]  = 0;
            end else if (en) begin
                ny = my[k];
                for (int c = 0; c < NC[k]; c++) begin
                    e = ev(k, c);
                    if (e[1]) ny[c] = 1'b1;
                    else if (e[0]) ny[c] = 1'b0;
                end
                if (ny == msk && !mad[k]) mc[k] = (mc[k] + 1) % (1 << CW[k]);
                my[k]  = ny;
                mad[k] = ny == msk;
                man[k] = ny == 4'h0;
            end
        end
        if (rst) live = 1'b1;
        #2;
        if (live)
            for (int k = 0; k < 5; k++) begin
                logic [3:0] eh;
                eh = 4'h0;
                for (int c = 0; c < NC[k]; c++) eh[c] = ev(k, c) == 2'b00;
                chk($sformatf("y[%0d]", k), 32'(dy[k]), 32'(my[k]));
                chk($sformatf("hold[%0d]", k), 32'(dh[k]), 32'(eh));
                chk($sformatf("all_data[%0d]", k), 32'(dad[k]), 32'(mad[k]));
                chk($sformatf("all_null[%0d]", k), 32'(dan[k]), 32'(man[k]));
                chk($sformatf("wave_cnt[%0d]", k), 32'(dc[k]), 32'(mc[k]));
            end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    initial begin
        for (int k = 0; k < 5; k++) xin[k] = 16'h0;
        // T1 reset
        tick(); tick();
        chk("t1_y", 32'(y0), 0);
        chk("t1_null", 32'(an0), 1);
        chk("t1_data", 32'(ad0), 0);
        chk("t1_cnt", 32'(c0), 0);
        chk("t1_yS", 32'(y3), 32'hF);
        chk("t1_dataS", 32'(ad3), 1);
        rst = 1'b0;
        // T2 TH34 set, hold, clear
        xin[0] = 16'h7; tick();
        chk("t2_y", 32'(y0), 1);
        chk("t2_data", 32'(ad0), 1);
        chk("t2_cnt", 32'(c0), 1);
        xin[0] = 16'h1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_y", 32'(y0), 1);
            chk("t2_hold", 32'(h0), 1);
        end
        xin[0] = 16'h0; tick();
        chk("t2_clr", 32'(y0), 0);
        chk("t2_null", 32'(an0), 1);
        // T3 partial from NULL then set
        xin[0] = 16'h3; tick();
        chk("t3_y", 32'(y0), 0);
        chk("t3_hold", 32'(h0), 1);
        xin[0] = 16'hB; tick();
        chk("t3_set", 32'(y0), 1);
        chk("t3_cnt", 32'(c0), 2);
        xin[0] = 16'h0; tick();
        // buffer N=1 M=1
        xin[4] = 16'h1; tick();
        chk("buf_1", 32'(y4), 1);
        xin[4] = 16'h0; tick();
        chk("buf_0", 32'(y4), 0);
        // T4 TH24w2
        xin[1] = 16'h1; tick();
        chk("t4_w2", 32'(y1), 1);
        xin[1] = 16'h6; tick();
        chk("t4_two", 32'(y1), 1);
        xin[1] = 16'h0; tick();
        chk("t4_clr", 32'(y1), 0);
        xin[1] = 16'h4; tick();
        chk("t4_one", 32'(y1), 0);
        chk("t4_hold", 32'(h1), 1);
        xin[1] = 16'h0; tick();
        // T5 wavefronts with 2-bit wrap
        for (int w = 1; w <= 5; w++) begin
            xin[2] = 16'h7777; tick();
            chk("t5_cnt", 32'(c2), 32'(w % 4));
            xin[2] = 16'h0; tick();
            chk("t5_null", 32'(an2), 1);
        end
        xin[2] = 16'h0007; tick();
        chk("t5_mix_d", 32'(ad2), 0);
        chk("t5_mix_n", 32'(an2), 0);
        xin[2] = 16'h0077; tick();
        xin[2] = 16'h0777; tick();
        chk("t5_stag_d", 32'(ad2), 0);
        chk("t5_stag_c", 32'(c2), 1);
        xin[2] = 16'h7777; tick();
        chk("t5_last_d", 32'(ad2), 1);
        chk("t5_last_c", 32'(c2), 2);
        xin[2] = 16'h7771; tick();
        chk("t5_hold_d", 32'(ad2), 1);
        xin[2] = 16'h7770; tick();
        chk("t5_part_d", 32'(ad2), 0);
        chk("t5_part_n", 32'(an2), 0);
        xin[2] = 16'h7777; tick();
        chk("t5_again", 32'(c2), 3);
        xin[2] = 16'h0; tick();
        // mixed pseudo-random traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 5; k++) xin[k] = 16'($urandom);
            en = ($urandom_range(0, 4) != 0);
            tick();
        end
        en = 1'b1;
        for (int k = 0; k < 5; k++) xin[k] = 16'h0;
        tick();
        // T6 set-type reset mid-wavefront, then enable freeze
        xin[3] = 16'h7777; tick();
        chk("t6_full", 32'(ad3), 1);
        xin[3] = 16'h7770; tick();
        chk("t6_mid", 32'(ad3), 0);
        rst = 1'b1; tick();
        chk("t6_rst_y", 32'(y3), 32'hF);
        chk("t6_rst_d", 32'(ad3), 1);
        chk("t6_rst_c", 32'(c3), 0);
        xin[3] = 16'h7777;
        rst = 1'b0; tick();
        chk("t6_rel_y", 32'(y3), 32'hF);
        chk("t6_rel_c", 32'(c3), 0);
        en = 1'b0;
        xin[3] = 16'h0; tick();
        chk("t6_frz_y", 32'(y3), 32'hF);
        chk("t6_frz_h0", 32'(h3), 0);
        xin[3] = 16'h1111; tick();
        chk("t6_frz_h", 32'(h3), 32'hF);
        chk("t6_frz_y2", 32'(y3), 32'hF);
        en = 1'b1; tick();
        chk("t6_en_y", 32'(y3), 32'hF);
        xin[3] = 16'h0; tick();
        chk("t6_clr_y", 32'(y3), 0);
        chk("t6_clr_n", 32'(an3), 1);
        chk("t6_clr_c", 32'(c3), 0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
